// File: rtl/dmem_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_controller_if
//  Description : Bus bundle for dmem_controller. Carries both requester
//                ports (p0 = core load/store unit, p1 = DMA/loader) and the
//                word-wide bus to the single-ported data_memory array.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (N = 0, 1)
//    pN_valid/pN_ready    request handshake
//    pN_write             1 = store, 0 = load
//    pN_size              00 byte, 01 half, 10 word, 11 illegal
//    pN_unsigned          zero-extend sub-word loads when 1
//    pN_addr/pN_wdata     byte address / LSB-aligned store data
//    pN_rsp_valid         one-cycle completion pulse
//    pN_rsp_err           misaligned / illegal-size flag for the response
//    pN_rsp_rdata         load result (0 for stores and errors)
//    mem_read/mem_write   memory strobes
//    mem_address          word-aligned memory address
//    mem_write_data       full word to write
//    mem_read_data        asynchronous read data from memory
//  Modports: slave = controller side, master = requester/memory side
// ============================================================================
interface dmem_controller_if;
    logic        p0_valid;
    logic        p0_ready;
    logic        p0_write;
    logic [1:0]  p0_size;
    logic        p0_unsigned;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_rsp_valid;
    logic        p0_rsp_err;
    logic [31:0] p0_rsp_rdata;

    logic        p1_valid;
    logic        p1_ready;
    logic        p1_write;
    logic [1:0]  p1_size;
    logic        p1_unsigned;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_rsp_valid;
    logic        p1_rsp_err;
    logic [31:0] p1_rsp_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  p0_valid, p0_write, p0_size, p0_unsigned, p0_addr, p0_wdata,
        output p0_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
        input  p1_valid, p1_write, p1_size, p1_unsigned, p1_addr, p1_wdata,
        output p1_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output p0_valid, p0_write, p0_size, p0_unsigned, p0_addr, p0_wdata,
        input  p0_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
        output p1_valid, p1_write, p1_size, p1_unsigned, p1_addr, p1_wdata,
        input  p1_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_controller
//  Description : Two-port sequencer/arbiter in front of a single-ported,
//                word-wide data memory. Converts byte/half/word accesses into
//                word operations: sub-word stores become read-modify-write,
//                sub-word loads are extracted and sign/zero extended.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ARB_MODE  0 = round-robin between ports, 1 = port 0 fixed priority
//  Ports
//    clk    in   system clock, all state changes on posedge
//    reset  in   synchronous active-high reset
//    bus    slave modport of dmem_controller_if (request ports + memory bus)
// ============================================================================
module dmem_controller #(
    parameter int ARB_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    dmem_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        RMW_WRITE = 2'd2,
        RESP_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t      state_q;
    logic        last_grant_q;
    logic        port_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        p0_rsp_valid_q, p1_rsp_valid_q;
    logic        p0_rsp_err_q,   p1_rsp_err_q;
    logic [31:0] p0_rsp_rdata_q, p1_rsp_rdata_q;

    logic        grant_d;
    logic        accept_d;
    logic        sel_write_d;
    logic [1:0]  sel_size_d;
    logic        sel_unsigned_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic        misalign_d;
    logic [31:0] byte_lane_d;
    logic [31:0] half_lane_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic        rsp_fire_d;
    logic        rsp_err_d;
    logic [31:0] rsp_data_d;
    logic        word_store_d;

    // ------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE. With both ports valid, the
    // round-robin mode hands the grant to the port that lost last time.
    // ------------------------------------------------------------------
    always_comb begin
        grant_d = 1'b0;
        if (bus.p0_valid && bus.p1_valid) begin
            grant_d = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else if (bus.p1_valid) begin
            grant_d = 1'b1;
        end
    end

    // Ready is suppressed under reset so a request is never seen as taken
    // on an edge where the controller discards it.
    assign bus.p0_ready = ~reset & (state_q == IDLE) & ~grant_d & bus.p0_valid;
    assign bus.p1_ready = ~reset & (state_q == IDLE) &  grant_d & bus.p1_valid;
    assign accept_d     = bus.p0_ready | bus.p1_ready;

    assign sel_write_d    = grant_d ? bus.p1_write    : bus.p0_write;
    assign sel_size_d     = grant_d ? bus.p1_size     : bus.p0_size;
    assign sel_unsigned_d = grant_d ? bus.p1_unsigned : bus.p0_unsigned;
    assign sel_addr_d     = grant_d ? bus.p1_addr     : bus.p0_addr;
    assign sel_wdata_d    = grant_d ? bus.p1_wdata    : bus.p0_wdata;

    assign misalign_d = (sel_size_d == SZ_ILL)
                      | ((sel_size_d == SZ_HALF) & sel_addr_d[0])
                      | ((sel_size_d == SZ_WORD) & (sel_addr_d[1:0] != 2'b00));

    assign word_store_d = write_q & (size_q == SZ_WORD);

    // ------------------------------------------------------------------
    // Load extraction and store merge, both working on the word that is
    // on mem_read_data while in ACCESS.
    // ------------------------------------------------------------------
    assign byte_lane_d = bus.mem_read_data >> {addr_q[1:0], 3'b000};
    assign half_lane_d = bus.mem_read_data >> {addr_q[1], 4'b0000};

    always_comb begin
        load_d  = bus.mem_read_data;
        merge_d = bus.mem_read_data;
        case (size_q)
            SZ_BYTE: begin
                load_d = unsigned_q ? {24'h0, byte_lane_d[7:0]}
                                    : {{24{byte_lane_d[7]}}, byte_lane_d[7:0]};
                merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_d = unsigned_q ? {16'h0, half_lane_d[15:0]}
                                    : {{16{half_lane_d[15]}}, half_lane_d[15:0]};
                merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_d  = bus.mem_read_data;
                merge_d = bus.mem_read_data;
            end
        endcase
    end

    // Response generation for the current state; routed to port_q below.
    always_comb begin
        rsp_fire_d = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = 32'h0;
        case (state_q)
            ACCESS: begin
                if (!write_q) begin
                    rsp_fire_d = 1'b1;
                    rsp_data_d = load_d;
                end else if (word_store_d) begin
                    rsp_fire_d = 1'b1;
                end
            end
            RMW_WRITE: rsp_fire_d = 1'b1;
            RESP_ERR: begin
                rsp_fire_d = 1'b1;
                rsp_err_d  = 1'b1;
            end
            default: rsp_fire_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer and all registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            port_q         <= 1'b0;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            merge_q        <= 32'h0;
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_err_q   <= 1'b0;
            p0_rsp_rdata_q <= 32'h0;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
            p1_rsp_rdata_q <= 32'h0;
        end else begin
            // Response strobes are single-cycle; rdata holds until the
            // next response on the same port.
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_err_q   <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
            if (rsp_fire_d) begin
                if (port_q) begin
                    p1_rsp_valid_q <= 1'b1;
                    p1_rsp_err_q   <= rsp_err_d;
                    p1_rsp_rdata_q <= rsp_data_d;
                end else begin
                    p0_rsp_valid_q <= 1'b1;
                    p0_rsp_err_q   <= rsp_err_d;
                    p0_rsp_rdata_q <= rsp_data_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        port_q       <= grant_d;
                        last_grant_q <= grant_d;
                        write_q      <= sel_write_d;
                        size_q       <= sel_size_d;
                        unsigned_q   <= sel_unsigned_d;
                        addr_q       <= sel_addr_d;
                        wdata_q      <= sel_wdata_d;
                        state_q      <= misalign_d ? RESP_ERR : ACCESS;
                    end
                end
                ACCESS: begin
                    if (write_q && !word_store_d) begin
                        merge_q <= merge_d;
                        state_q <= RMW_WRITE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RMW_WRITE: state_q <= IDLE;
                RESP_ERR:  state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign bus.p0_rsp_valid = p0_rsp_valid_q;
    assign bus.p0_rsp_err   = p0_rsp_err_q;
    assign bus.p0_rsp_rdata = p0_rsp_rdata_q;
    assign bus.p1_rsp_valid = p1_rsp_valid_q;
    assign bus.p1_rsp_err   = p1_rsp_err_q;
    assign bus.p1_rsp_rdata = p1_rsp_rdata_q;

    // Strobes gated by reset so an abort can never leave a partial write.
    assign bus.mem_read  = ~reset & (state_q == ACCESS) & ~word_store_d;
    assign bus.mem_write = ~reset & (((state_q == ACCESS) & word_store_d)
                                     | (state_q == RMW_WRITE));
    assign bus.mem_address    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_data = (state_q == RMW_WRITE) ? merge_q : wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_controller
//  Description : Self-checking bench for dmem_controller. A reference memory
//                model predicts every response, which is queued per port at
//                accept time and compared when the DUT pulses rsp_valid.
//                A second instance with ARB_MODE=1 checks fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_controller;

    logic clk;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    dmem_controller_if bus0();
    dmem_controller_if bus1();

    dmem_controller #(.ARB_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_controller #(.ARB_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind dut0: asynchronous read, write on posedge.
    logic [31:0] tb_mem  [0:63] = '{default: 32'h0};
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};

    assign bus0.mem_read_data = tb_mem[bus0.mem_address[7:2]];
    assign bus1.mem_read_data = 32'h0;

    always @(posedge clk) begin
        if (bus0.mem_write === 1'b1) tb_mem[bus0.mem_address[7:2]] <= bus0.mem_write_data;
    end

    // Expected {err, rdata} queues.
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] e0, e1;

    always @(negedge clk) begin
        if (bus0.p0_rsp_valid === 1'b1) begin
            vectors++;
            if (exp_q0.size() == 0) begin
                miscompares++;
                $display("FAIL p0_unexpected_rsp: got err=%0b rdata=%h, required no response",
                         bus0.p0_rsp_err, bus0.p0_rsp_rdata);
            end else begin
                e0 = exp_q0.pop_front();
                if ({bus0.p0_rsp_err, bus0.p0_rsp_rdata} !== e0) begin
                    miscompares++;
                    $display("FAIL p0_rsp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             bus0.p0_rsp_err, bus0.p0_rsp_rdata, e0[32], e0[31:0]);
                end
            end
        end
        if (bus0.p1_rsp_valid === 1'b1) begin
            vectors++;
            if (exp_q1.size() == 0) begin
                miscompares++;
                $display("FAIL p1_unexpected_rsp: got err=%0b rdata=%h, required no response",
                         bus0.p1_rsp_err, bus0.p1_rsp_rdata);
            end else begin
                e1 = exp_q1.pop_front();
                if ({bus0.p1_rsp_err, bus0.p1_rsp_rdata} !== e1) begin
                    miscompares++;
                    $display("FAIL p1_rsp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             bus0.p1_rsp_err, bus0.p1_rsp_rdata, e1[32], e1[31:0]);
                end
            end
        end
    end

    // Reference behaviour of one access; updates ref_mem for stores.
    function automatic logic [32:0] model(input bit wr, input logic [1:0] sz, input bit uns,
                                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, r;
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))
            return {1'b1, 32'h0};
        w = ref_mem[a[7:2]];
        if (wr) begin
            if (sz == 2'b00)      w[8*a[1:0] +: 8] = wd[7:0];
            else if (sz == 2'b01) w[16*a[1] +: 16] = wd[15:0];
            else                  w = wd;
            ref_mem[a[7:2]] = w;
            return {1'b0, 32'h0};
        end
        if (sz == 2'b00) begin
            r = w >> (8*a[1:0]);
            r = uns ? {24'h0, r[7:0]} : {{24{r[7]}}, r[7:0]};
        end else if (sz == 2'b01) begin
            r = w >> (16*a[1]);
            r = uns ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
        end else begin
            r = w;
        end
        return {1'b0, r};
    endfunction

    task automatic drive(input bit port, input bit v, input bit wr, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] wd);
        if (!port) begin
            bus0.p0_valid = v; bus0.p0_write = wr; bus0.p0_size = sz;
            bus0.p0_unsigned = uns; bus0.p0_addr = a; bus0.p0_wdata = wd;
        end else begin
            bus0.p1_valid = v; bus0.p1_write = wr; bus0.p1_size = sz;
            bus0.p1_unsigned = uns; bus0.p1_addr = a; bus0.p1_wdata = wd;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Single request on dut0; reports latency (cycles after accept edge) and
    // the cycle/data of the first mem_read / mem_write it saw.
    task automatic issue(input bit port, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int rd_cyc, output int wr_cyc,
                         output logic [31:0] wr_data, output logic [31:0] wr_addr);
        bit acc;
        lat = 0; rd_cyc = 0; wr_cyc = 0; wr_data = '0; wr_addr = '0; acc = 1'b0;
        @(posedge clk); #1;
        drive(port, 1'b1, wr, sz, uns, a, wd);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if ((port ? bus0.p1_ready : bus0.p0_ready) === 1'b1) acc = 1'b1;
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: port %0d got no ready, required ready within 20 cycles", port);
            drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            return;
        end
        if (port) exp_q1.push_back(model(wr, sz, uns, a, wd));
        else      exp_q0.push_back(model(wr, sz, uns, a, wd));
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (bus0.mem_read === 1'b1 && rd_cyc == 0) rd_cyc = k;
            if (bus0.mem_write === 1'b1 && wr_cyc == 0) begin
                wr_cyc = k; wr_data = bus0.mem_write_data; wr_addr = bus0.mem_address;
            end
            if ((port ? bus0.p1_rsp_valid : bus0.p0_rsp_valid) === 1'b1) lat = k;
        end
        if (lat == 0) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: port %0d got no rsp_valid, required one within 10 cycles", port);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++) @(negedge clk);
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0",
                     exp_q0.size(), exp_q1.size());
        end
    endtask

    int lat, rc, wc;
    logic [31:0] wd, wa;

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        bus1.p0_valid = 0; bus1.p0_write = 0; bus1.p0_size = 2'b10; bus1.p0_unsigned = 0;
        bus1.p0_addr = 0; bus1.p0_wdata = 0;
        bus1.p1_valid = 0; bus1.p1_write = 0; bus1.p1_size = 2'b10; bus1.p1_unsigned = 0;
        bus1.p1_addr = 0; bus1.p1_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus0.p0_rsp_valid !== 1'b0 || bus0.p1_rsp_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_rsp_valid: got %b%b, required 00", bus0.p0_rsp_valid, bus0.p1_rsp_valid); end
        vectors++; if (bus0.p0_rsp_err !== 1'b0 || bus0.p1_rsp_err !== 1'b0) begin miscompares++;
            $display("FAIL reset_rsp_err: got %b%b, required 00", bus0.p0_rsp_err, bus0.p1_rsp_err); end
        vectors++; if (bus0.p0_rsp_rdata !== 32'h0 || bus0.p1_rsp_rdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_rsp_rdata: got %h/%h, required 0/0", bus0.p0_rsp_rdata, bus0.p1_rsp_rdata); end
        vectors++; if (bus0.mem_address !== 32'h0) begin miscompares++;
            $display("FAIL reset_mem_address: got %h, required 00000000", bus0.mem_address); end
        vectors++; if (bus0.mem_read !== 1'b0 || bus0.mem_write !== 1'b0) begin miscompares++;
            $display("FAIL reset_mem_strobes: got rd=%b wr=%b, required 0/0", bus0.mem_read, bus0.mem_write); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_word_store_load();
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, rc, wc, wd, wa);
        vectors++; if (wc != 1 || rc != 0) begin miscompares++;
            $display("FAIL word_store_strobes: got wr_cyc=%0d rd_cyc=%0d, required 1/0", wc, rc); end
        vectors++; if (wd !== 32'hDEADBEEF || wa !== 32'h40) begin miscompares++;
            $display("FAIL word_store_bus: got data=%h addr=%h, required deadbeef/00000040", wd, wa); end
        vectors++; if (lat != 2) begin miscompares++;
            $display("FAIL word_store_latency: got %0d, required 2", lat); end
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rc, wc, wd, wa);
        vectors++; if (lat != 2 || rc != 1 || wc != 0) begin miscompares++;
            $display("FAIL word_load_timing: got lat=%0d rd=%0d wr=%0d, required 2/1/0", lat, rc, wc); end
        vectors++; if (bus0.p0_rsp_rdata !== 32'hDEADBEEF) begin miscompares++;
            $display("FAIL word_load_data: got %h, required deadbeef", bus0.p0_rsp_rdata); end
    endtask

    task automatic test_byte_store_rmw();
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, lat, rc, wc, wd, wa);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, lat, rc, wc, wd, wa);
        vectors++; if (rc != 1 || wc != 2) begin miscompares++;
            $display("FAIL rmw_sequence: got rd_cyc=%0d wr_cyc=%0d, required 1/2", rc, wc); end
        vectors++; if (wd !== 32'h1122AA44 || wa !== 32'h40) begin miscompares++;
            $display("FAIL rmw_merge: got data=%h addr=%h, required 1122aa44/00000040", wd, wa); end
        vectors++; if (lat != 3) begin miscompares++;
            $display("FAIL rmw_latency: got %0d, required 3", lat); end
        vectors++; if (tb_mem[16] !== 32'h1122AA44) begin miscompares++;
            $display("FAIL rmw_memory: got %h, required 1122aa44", tb_mem[16]); end
        // Halfword store into the upper lane through port 1.
        issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, lat, rc, wc, wd, wa);
        vectors++; if (wd !== 32'hBEEFAA44 || lat != 3) begin miscompares++;
            $display("FAIL half_rmw: got data=%h lat=%0d, required beefaa44/3", wd, lat); end
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1122AA44, lat, rc, wc, wd, wa);
    endtask

    task automatic test_load_extend();
        logic [31:0] req [0:5];
        logic [1:0]  sz  [0:5];
        bit          uns [0:5];
        logic [31:0] ad  [0:5];
        req = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80, 32'h00000000};
        sz  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        uns = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ad  = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h11, 32'h12};
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h000080FF, lat, rc, wc, wd, wa);
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 1'b0, sz[i], uns[i], ad[i], 32'h0, lat, rc, wc, wd, wa);
            vectors++; if (bus0.p0_rsp_rdata !== req[i] || lat != 2) begin miscompares++;
                $display("FAIL load_extend[%0d]: got rdata=%h lat=%0d, required %h/2",
                         i, bus0.p0_rsp_rdata, lat, req[i]); end
        end
    endtask

    task automatic test_errors();
        bit          prt [0:2];
        bit          wr  [0:2];
        logic [1:0]  sz  [0:2];
        logic [31:0] ad  [0:2];
        prt = '{1'b0, 1'b1, 1'b0};
        wr  = '{1'b0, 1'b1, 1'b0};
        sz  = '{2'b10, 2'b01, 2'b11};
        ad  = '{32'h42, 32'h13, 32'h20};
        for (int i = 0; i < 3; i++) begin
            issue(prt[i], wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, lat, rc, wc, wd, wa);
            vectors++; if (rc != 0 || wc != 0 || lat != 2) begin miscompares++;
                $display("FAIL error_case[%0d]: got rd=%0d wr=%0d lat=%0d, required 0/0/2", i, rc, wc, lat); end
        end
        vectors++; if (tb_mem[4] !== 32'h000080FF) begin miscompares++;
            $display("FAIL error_no_write: got %h, required 000080ff", tb_mem[4]); end
    endtask

    task automatic test_arbitration();
        bit got;
        reset_dut();
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (bus0.p0_ready === 1'b1 || bus0.p1_ready === 1'b1) got = 1'b1;
            end
            vectors++;
            if (!got) begin miscompares++;
                $display("FAIL rr_timeout: grant %0d got none, required one", g); break; end
            if ({bus0.p0_ready, bus0.p1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++;
                $display("FAIL rr_grant[%0d]: got ready=%b%b, required port %0d", g,
                         bus0.p0_ready, bus0.p1_ready, g % 2); end
            if (bus0.p1_ready === 1'b1) exp_q1.push_back(model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
            else                        exp_q0.push_back(model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0));
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drain();

        bus1.p0_valid = 1'b1; bus1.p1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (bus1.p0_ready === 1'b1 || bus1.p1_ready === 1'b1) got = 1'b1;
            end
            vectors++;
            if ({bus1.p0_ready, bus1.p1_ready} !== 2'b10) begin miscompares++;
                $display("FAIL fixed_grant[%0d]: got ready=%b%b, required 10", g,
                         bus1.p0_ready, bus1.p1_ready); end
            @(posedge clk); #1;
        end
        bus1.p0_valid = 1'b0; bus1.p1_valid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_rmw();
        bit got;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h00000055);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus0.p0_ready === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL abort_accept: got no ready, required ready"); end
        @(posedge clk); #1;                                  // cycle 1: ACCESS
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 reset = 1'b1;                     // cycle 2: RMW_WRITE
        @(negedge clk);
        vectors++; if (bus0.mem_write !== 1'b0) begin miscompares++;
            $display("FAIL abort_mem_write: got %b, required 0", bus0.mem_write); end
        @(posedge clk); #1 reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++; if ({bus0.p0_ready, bus0.p1_ready} !== 2'b10) begin miscompares++;
            $display("FAIL abort_idle_grant: got ready=%b%b, required 10", bus0.p0_ready, bus0.p1_ready); end
        if (bus0.p0_ready === 1'b1) exp_q0.push_back(model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus0.p1_ready === 1'b1) got = 1'b1;
        end
        if (got) exp_q1.push_back(model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drain();
        vectors++; if (tb_mem[16] !== 32'h1122AA44) begin miscompares++;
            $display("FAIL abort_memory: got %h, required 1122aa44", tb_mem[16]); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_store_rmw();
        test_load_extend();
        test_errors();
        test_arbitration();
        test_reset_mid_rmw();
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
